matrix_host_link: RTL

Host-side initiator for the 32-bit coprocessor handshake link. It drives the word that the matrix control unit samples and reads back the word that the control unit returns. The block replays a 25-entry operand buffer (pixel, kernel, third operand) into the control unit, waits for processing, then pulls back 25 signed result bytes into a local result file. It sits in fabric in place of the HPS software driver, on the same clock as the control unit, and is loaded and started through a simple register-style port.

---
 rtl/matrix_host_link_if.sv | 8 +
 rtl/matrix_host_link.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_host_link_if.sv
// Coprocessor handshake link: the host drives cop_data_out, the control unit returns cop_data_in.
interface matrix_host_link_if;
  logic [31:0] cop_data_out;
  logic [31:0] cop_data_in;

  modport master (output cop_data_out, input cop_data_in);
  modport slave  (input cop_data_out, output cop_data_in);
endinterface

// File: rtl/matrix_host_link.sv
// Host-side initiator: replays a 25-entry operand buffer to the matrix control unit,
// waits for processing, then reads 25 result bytes back into a local result file.
module matrix_host_link #(
  parameter int unsigned PROC_WAIT = 32,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned LOW_HOLD  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cfg_we,
  input  logic [4:0]         i_cfg_addr,
  input  logic [23:0]        i_cfg_wdata,
  input  logic [2:0]         i_opcode,
  input  logic [1:0]         i_size,
  input  logic               i_go,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  input  logic [4:0]         i_res_addr,
  output logic [7:0]         o_res_data,
  matrix_host_link_if.master cop
);

  localparam int unsigned   NENT         = 25;
  localparam int unsigned   CW           = $clog2(TIMEOUT + PROC_WAIT + LOW_HOLD + 4);
  localparam logic [CW-1:0] C_ONE        = CW'(1);
  localparam logic [CW-1:0] C_START_LAST = CW'(1);
  localparam logic [CW-1:0] C_HOLD       = CW'(LOW_HOLD);
  localparam logic [CW-1:0] C_PWAIT_LAST = CW'(PROC_WAIT - 1);
  localparam logic [CW-1:0] C_TO_LAST    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_ABORT_LAST = CW'(3);
  localparam logic [4:0]    IDX_LAST     = 5'(NENT - 1);
  localparam logic [4:0]    N_ENT5       = 5'(NENT);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_SEND_LO, S_SEND_HI, S_PWAIT,
    S_RECV_LO, S_RECV_HI, S_FLUSH_LO, S_FLUSH_HI, S_ABORT
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_idx;
  logic [2:0]    r_opcode;
  logic [1:0]    r_size;
  logic          r_error;
  logic [23:0]   r_buf [NENT];
  logic [7:0]    r_res [NENT];
  logic [7:0]    r_res_data;

  logic          w_ack, w_timeout, w_hold_ok;
  logic          w_go_acc, w_idx_inc, w_idx_clr, w_res_we, w_err_set, w_done;
  logic [23:0]   w_entry;
  logic [31:0]   w_cop_out;
  logic          w_unused_in;

  assign w_ack       = cop.cop_data_in[31];
  assign w_unused_in = ^cop.cop_data_in[30:8];
  // r_cnt restarts on every state change, so it doubles as hold, wait and timeout counter
  assign w_timeout   = (r_cnt == C_TO_LAST);
  assign w_hold_ok   = (r_cnt >= C_HOLD);
  assign w_entry     = r_buf[r_idx];

  always_comb begin
    w_next    = r_state;
    w_go_acc  = 1'b0;
    w_idx_inc = 1'b0;
    w_idx_clr = 1'b0;
    w_res_we  = 1'b0;
    w_err_set = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: if (i_go) begin
        w_go_acc  = 1'b1;
        w_idx_clr = 1'b1;
        w_next    = S_START;
      end
      S_START: if (r_cnt == C_START_LAST) w_next = S_SEND_LO;
      S_SEND_LO: begin
        if (w_hold_ok && !w_ack) w_next = S_SEND_HI;
        else if (w_timeout)      w_next = S_ABORT;
      end
      S_SEND_HI: begin
        if (w_ack) begin
          if (r_idx == IDX_LAST) w_next = S_PWAIT;
          else begin
            w_idx_inc = 1'b1;
            w_next    = S_SEND_LO;
          end
        end else if (w_timeout) w_next = S_ABORT;
      end
      S_PWAIT: if (r_cnt == C_PWAIT_LAST) begin
        w_idx_clr = 1'b1;
        w_next    = S_RECV_LO;
      end
      S_RECV_LO: begin
        if (w_hold_ok && !w_ack) w_next = S_RECV_HI;
        else if (w_timeout)      w_next = S_ABORT;
      end
      S_RECV_HI: begin
        if (w_ack) begin
          w_res_we = 1'b1;
          if (r_idx == IDX_LAST) w_next = S_FLUSH_LO;
          else begin
            w_idx_inc = 1'b1;
            w_next    = S_RECV_LO;
          end
        end else if (w_timeout) w_next = S_ABORT;
      end
      S_FLUSH_LO: begin
        if (w_hold_ok && !w_ack) w_next = S_FLUSH_HI;
        else if (w_timeout)      w_next = S_ABORT;
      end
      S_FLUSH_HI: begin
        if (w_ack) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_timeout) w_next = S_ABORT;
      end
      S_ABORT: if (r_cnt == C_ABORT_LAST) begin
        w_err_set = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cop_out = '0;
    if (r_state != S_IDLE && r_state != S_ABORT) begin
      w_cop_out[18:16] = r_opcode;
      w_cop_out[20:19] = r_size;
    end
    if (r_state == S_SEND_LO || r_state == S_SEND_HI) begin
      w_cop_out[7:0]   = w_entry[7:0];
      w_cop_out[15:8]  = w_entry[15:8];
      w_cop_out[28:21] = w_entry[23:16];
    end
    w_cop_out[29] = (r_state == S_ABORT);
    w_cop_out[30] = (r_state == S_START);
    w_cop_out[31] = (r_state == S_SEND_HI) || (r_state == S_RECV_HI) || (r_state == S_FLUSH_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_opcode <= '0;
      r_size   <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + C_ONE;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 5'd1;
      if (w_go_acc) begin
        r_opcode <= i_opcode;
        r_size   <= i_size;
        r_error  <= 1'b0;
      end else if (w_err_set) begin
        r_error  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NENT; i++) r_buf[i] <= '0;
    end else if (i_cfg_we && r_state == S_IDLE && !w_go_acc && i_cfg_addr < N_ENT5) begin
      r_buf[i_cfg_addr] <= i_cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NENT; i++) r_res[i] <= '0;
      r_res_data <= '0;
    end else begin
      if (w_res_we) r_res[r_idx] <= cop.cop_data_in[7:0];
      r_res_data <= (i_res_addr < N_ENT5) ? r_res[i_res_addr] : '0;
    end
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = w_done;
  assign o_error          = r_error;
  assign o_res_data       = r_res_data;
  assign cop.cop_data_out = w_cop_out;

endmodule
